// File: rtl/sop_expression_pkg.sv
// Shared constants and types for the sum-of-products evaluator.
//   SOP_IDX_W      : width of the {a,b,c,d} table index
//   SOP_TT_W       : width of the truth table (one bit per minterm)
//   SOP_DEFAULT_TT : a*b + c*d
package sop_expression_pkg;
  localparam int SOP_IDX_W = 4;
  localparam int SOP_TT_W  = 16;
  localparam logic [SOP_TT_W-1:0] SOP_DEFAULT_TT = 16'hF888;

  typedef logic [SOP_TT_W-1:0]  sop_tt_t;
  typedef logic [SOP_IDX_W-1:0] sop_idx_t;
endpackage

// File: rtl/sop_lut16.sv
// Combinational 16-to-1 truth-table lookup.
//   tt_i  : truth table, bit i is the function value for index i
//   idx_i : index {a,b,c,d}
//   bit_o : selected table bit
module sop_lut16
  import sop_expression_pkg::*;
(
  input  sop_tt_t  tt_i,
  input  sop_idx_t idx_i,
  output logic     bit_o
);
  assign bit_o = tt_i[idx_i];
endmodule

// File: rtl/sop_expression.sv
// Registered sum-of-products evaluator: out = table[{a,b,c,d}], one-cycle latency,
// no backpressure.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid, a..d    : evaluation request (a is the index MSB)
//   tt_we, tt_wdata   : truth-table write (effective only with SOP_PROG_EN)
//   out, out_valid    : registered result and its fresh-this-cycle flag
//   tt_rdata          : current truth table
// Build option: define SOP_PROG_EN to make the table a runtime-writable register;
// otherwise the table is the constant MINTERMS and the write port is ignored.
module sop_expression
  import sop_expression_pkg::*;
#(
  parameter sop_tt_t MINTERMS = SOP_DEFAULT_TT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          a,
  input  logic          b,
  input  logic          c,
  input  logic          d,
  input  logic          tt_we,
  input  logic [15:0]   tt_wdata,
  output logic          out,
  output logic          out_valid,
  output logic [15:0]   tt_rdata
);
  sop_tt_t  tbl;
  sop_idx_t idx;
  logic     lut_bit;
  logic     out_q, out_d;
  logic     vld_q, vld_d;

  assign idx = {a, b, c, d};

`ifdef SOP_PROG_EN
  sop_tt_t tbl_q;
  // The lookup reads tbl_q before this edge's write lands, so a same-edge
  // write and evaluation sees the old table.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     tbl_q <= MINTERMS;
    else if (tt_we) tbl_q <= tt_wdata;
  end
  assign tbl = tbl_q;
`else
  assign tbl = MINTERMS;
  logic unused_tt;
  assign unused_tt = ^{tt_we, tt_wdata};
`endif

  assign tt_rdata = tbl;

  sop_lut16 u_lut (
    .tt_i  (tbl),
    .idx_i (idx),
    .bit_o (lut_bit)
  );

  // out holds its last value across idle cycles; only out_valid drops.
  always_comb begin
    out_d = out_q;
    vld_d = in_valid;
    if (in_valid) out_d = lut_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
    end
  end

  assign out       = out_q;
  assign out_valid = vld_q;
endmodule

// File: tb/tb_sop_expression.sv
module tb_sop_expression;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid = 1'b0;
  logic        a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic        tt_we = 1'b0;
  logic [15:0] tt_wdata = 16'h0;
  logic        out, out_valid;
  logic [15:0] tt_rdata;

  localparam logic [15:0] DEF_TT = 16'hF888;
`ifdef SOP_PROG_EN
  localparam bit PROG = 1'b1;
`else
  localparam bit PROG = 1'b0;
`endif

  sop_expression dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .d(d),
    .tt_we(tt_we), .tt_wdata(tt_wdata),
    .out(out), .out_valid(out_valid), .tt_rdata(tt_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic exp_q[$];

  // Reference state: the table contents and the last result value.
  logic [15:0] tbl_m = DEF_TT;
  logic        last_exp = 1'b0;
  logic        prev_v = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: every presented result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("spurious_out_valid", 16'(out_valid), 16'h0);
      else chk("result", 16'(out), 16'(exp_q.pop_front()));
    end
  end

  // One stimulus cycle. Before driving, verify idle behaviour and table readback.
  task automatic cyc(input bit v, input logic [3:0] idx, input bit we, input logic [15:0] wd);
    @(negedge clk);
    if (!prev_v) begin
      chk("idle_valid", 16'(out_valid), 16'h0);
      chk("idle_hold", 16'(out), 16'(last_exp));
    end
    chk("tt_rdata", tt_rdata, tbl_m);
    in_valid = v;
    {a, b, c, d} = idx;
    tt_we = we;
    tt_wdata = wd;
    if (v) begin
      last_exp = tbl_m[idx];
      exp_q.push_back(last_exp);
    end
    if (we && PROG) tbl_m = wd;
    prev_v = v;
  endtask

  // Reset asserted between edges right after a result was registered.
  task automatic mid_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    tt_we = 1'b0;
    #1;
    chk("rst_out", 16'(out), 16'h0);
    chk("rst_valid", 16'(out_valid), 16'h0);
    chk("rst_tt", tt_rdata, DEF_TT);
    exp_q.delete();
    tbl_m = DEF_TT;
    last_exp = 1'b0;
    prev_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_out", 16'(out), 16'h0);
    chk("reset_valid", 16'(out_valid), 16'h0);
    chk("reset_tt", tt_rdata, DEF_TT);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Sweep all indices back to back under the default table.
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'(i), 1'b0, 16'h0);
    // Result 0, then idle with abcd=1111: valid drops, out stays 0.
    cyc(1'b1, 4'd0, 1'b0, 16'h0);
    cyc(1'b0, 4'hF, 1'b0, 16'h0);
    cyc(1'b0, 4'hF, 1'b0, 16'h0);

    // Same-edge write and evaluate: evaluation uses the pre-write table.
    cyc(1'b1, 4'd3, 1'b1, 16'h0001);
    cyc(1'b1, 4'd0, 1'b0, 16'h0);
    cyc(1'b1, 4'hF, 1'b0, 16'h0);
    cyc(1'b0, 4'h0, 1'b1, 16'hFFFF);
    cyc(1'b1, 4'd0, 1'b0, 16'h0);
    cyc(1'b1, 4'd5, 1'b0, 16'h0);

    // Reset mid-stream with a possibly modified table.
    mid_reset();
    cyc(1'b0, 4'h0, 1'b0, 16'h0);
    cyc(1'b1, 4'hC, 1'b0, 16'h0);

    // Randomized traffic with occasional table writes and resets.
    for (int n = 0; n < 300; n++) begin
      cyc(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 7) == 0), 16'($urandom));
      if (n % 97 == 50) mid_reset();
    end

    cyc(1'b0, 4'h0, 1'b0, 16'h0);
    cyc(1'b0, 4'h0, 1'b0, 16'h0);
    @(negedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sop_expression.md
SOP_EXPRESSION -- requirements
Module: sop_expression

Interface
REQ-001 Parameter MINTERMS, default 16'hF888, meaning reset-time truth table; bit i is the output for index i = {a,b,c,d}; default implements out = a·b + c·d.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  qualifies a, b, c, d for evaluation this cycle.
REQ-006 a  input  1  function input, index MSB (bit 3).
REQ-007 b  input  1  function input, index bit 2.
REQ-008 c  input  1  function input, index bit 1.
REQ-009 d  input  1  function input, index LSB (bit 0).
REQ-010 tt_we  input  1  truth-table write strobe.
REQ-011 tt_wdata  input  16  new truth table.
REQ-012 out  output  1  registered function result.
REQ-013 out_valid  output  1  out holds a fresh result this cycle.
REQ-014 tt_rdata  output  16  current truth table, combinational from the table register.

Function
REQ-015 Index SHALL be {a,b,c,d}, 0..15; result SHALL be table[index] (sum of selected minterms).
REQ-016 Latency SHALL be 1 cycle: in_valid=1 at edge N gives out=table[index] and out_valid=1 after edge N.
REQ-017 in_valid=0 at an edge SHALL give out_valid=0 after that edge; out SHALL hold its last value.
REQ-018 Back-to-back in_valid=1 SHALL give one result per cycle with no bubbles.
REQ-019 tt_we=1 at an edge SHALL load tt_wdata into the table at that edge (SOP_PROG_EN builds only).
REQ-020 If tt_we and in_valid are both 1 at the same edge, the evaluation SHALL use the pre-write table; the new table applies from the next edge.
REQ-021 There SHALL be no backpressure; results not consumed are overwritten.

Reset
REQ-022 rst_n=0 SHALL immediately force out=0 and out_valid=0, independent of clk.
REQ-023 rst_n=0 SHALL immediately force table=MINTERMS, so tt_rdata=MINTERMS.
REQ-024 Reset asserted mid-stream SHALL discard the pending result; the first valid result after release needs a new in_valid.

Configuration
REQ-025 Macro SOP_PROG_EN defined: the table SHALL be a runtime-writable register per REQ-019/020.
REQ-026 SOP_PROG_EN undefined: the table SHALL be the constant MINTERMS; tt_we and tt_wdata SHALL be ignored; tt_rdata SHALL equal MINTERMS.
REQ-027 The port list SHALL be identical in both builds.

Structure
REQ-028 Package sop_expression_pkg SHALL hold SOP_IDX_W=4, SOP_TT_W=16, the default table constant 16'hF888 and the truth-table typedef.
REQ-029 Sub-module sop_lut16 SHALL perform the combinational 16-to-1 table lookup; sop_expression SHALL provide the registers and the table storage.

Verification
REQ-030 Reset: rst_n=0 -> out=0, out_valid=0, tt_rdata=16'hF888.
REQ-031 Sweep {a,b,c,d}=0..15 with in_valid=1, 10 ns steps -> one cycle later out=1 only for indices 3, 7, 11, 12, 13, 14, 15, with out_valid=1 throughout.
REQ-032 in_valid=0 with abcd=1111 after a result of 0 -> out_valid=0 and out stays 0.
REQ-033 SOP_PROG_EN:
- write tt_wdata=16'h0001, then abcd=0000 -> out=1;
- abcd=1111 -> out=0;
- tt_we together with abcd=0011 under the default table -> out=1 (old table).
REQ-034 SOP_PROG_EN undefined: tt_we=1 with tt_wdata=16'hFFFF, then abcd=0000 -> out=0, tt_rdata=16'hF888.
REQ-035 Assert rst_n between clock edges during a stream -> out and out_valid drop to 0 before the next edge, and the table returns to 16'hF888.
